bit32_div: RTL and testbench

BIT32_DIV -- requirements
Module: bit32_div

---
 rtl/bit32_div_pkg.sv | 46 ++++
 rtl/div_step.sv | 40 ++++
 rtl/bit32_div.sv | 165 ++++++++++++++++
 tb/tb_bit32_div.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit32_div_pkg.sv
// -----------------------------------------------------------------------------
// bit32_div_pkg
// Shared constants, FSM state type and the 32-bit invert / adder helpers used
// by the signed divider.
//   DIV_WIDTH : operand and result width (32)
//   DIV_ITER  : restoring iterations per division (32)
//   DIV_CNT_W : width of the iteration counter
//   state_t   : IDLE / RUN / FIX / DONE
//   inv32     : bitwise invert block
//   add32     : 32-bit adder block
//   neg32     : two's-complement negation built from inv32 + add32
//   abs32     : magnitude of a signed 32-bit value
// -----------------------------------------------------------------------------
package bit32_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [DIV_WIDTH-1:0] inv32(input logic [DIV_WIDTH-1:0] x);
    return ~x;
  endfunction

  function automatic logic [DIV_WIDTH-1:0] add32(input logic [DIV_WIDTH-1:0] a,
                                                 input logic [DIV_WIDTH-1:0] b);
    return a + b;
  endfunction

  // Negation is always invert-plus-one through the shared blocks.
  function automatic logic [DIV_WIDTH-1:0] neg32(input logic [DIV_WIDTH-1:0] x);
    return add32(inv32(x), {{(DIV_WIDTH-1){1'b0}}, 1'b1});
  endfunction

  // 0x80000000 maps to itself, which read as unsigned is the correct magnitude.
  function automatic logic [DIV_WIDTH-1:0] abs32(input logic [DIV_WIDTH-1:0] x);
    return x[DIV_WIDTH-1] ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step on unsigned magnitudes.
//   rem_in  : partial remainder before the step
//   quo_in  : dividend/quotient shift register before the step
//   dvs     : divisor magnitude (nonzero)
//   rem_out : partial remainder after the step
//   quo_out : shift register after the step, new quotient bit in the LSB
// The {rem, quo} pair is shifted left by one, the divisor is trial-subtracted
// from the 33-bit upper part, and the difference is kept only when it does
// not borrow.
// -----------------------------------------------------------------------------
module div_step
  import bit32_div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem_in,
  input  logic [DIV_WIDTH-1:0] quo_in,
  input  logic [DIV_WIDTH-1:0] dvs,
  output logic [DIV_WIDTH-1:0] rem_out,
  output logic [DIV_WIDTH-1:0] quo_out
);

  logic [DIV_WIDTH:0]   shifted;
  logic [DIV_WIDTH+1:0] trial;
  logic                 fits;
  logic                 unused_trial_bit;

  assign shifted = {rem_in, quo_in[DIV_WIDTH-1]};

  // 33-bit subtract with an explicit borrow-out bit on top.
  assign trial = {1'b0, shifted} - {2'b00, dvs};
  assign fits  = ~trial[DIV_WIDTH+1];

  // When the subtraction fits, the difference is below the divisor, so its
  // bit 32 is always zero and only the low 32 bits are carried forward.
  assign rem_out          = fits ? trial[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];
  assign quo_out          = {quo_in[DIV_WIDTH-2:0], fits};
  assign unused_trial_bit = trial[DIV_WIDTH];

endmodule

// File: rtl/bit32_div.sv
// -----------------------------------------------------------------------------
// bit32_div
// Sequential signed 32-bit divider (restoring, one bit per clock).
//   clock     : rising-edge clock
//   reset_n   : synchronous active-low reset
//   start     : request, looked at only in IDLE
//   dividend  : signed numerator, captured on acceptance
//   divisor   : signed denominator, captured on acceptance
//   quotient  : registered signed quotient (truncated toward zero)
//   remainder : registered signed remainder (sign of the dividend)
//   busy      : high from the cycle after acceptance until ready
//   ready     : one-cycle pulse, results valid in that cycle
//   exception : divide-by-zero flag, valid with ready, held until next accept
//   state_dbg : current FSM state for observation
//
// Handshake: a request is accepted on a rising edge where the FSM is in IDLE
// and start=1. Nothing is queued; start in any other state is ignored. The
// results and exception are held from the ready pulse until the next accept.
//
// Timeline for an accept at edge N: RUN for 32 cycles (edges N+1..N+32 do the
// steps), FIX registers the signed results at N+33, DONE lasts one cycle and
// the registered ready pulse follows it (cycle after N+34). A zero divisor
// skips RUN and spends one FIX cycle registering the zero results, so ready
// appears in the cycle after N+2.
// -----------------------------------------------------------------------------
module bit32_div
  import bit32_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH  // only 32 is supported
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             ready,
  output logic             exception,
  output state_t           state_dbg
);

  state_t                 state;
  state_t                 state_nxt;

  logic [DIV_CNT_W-1:0]   count;
  logic [DIV_WIDTH-1:0]   rem_r;     // partial remainder magnitude
  logic [DIV_WIDTH-1:0]   quo_r;     // dividend magnitude shifting into quotient
  logic [DIV_WIDTH-1:0]   dvs_r;     // divisor magnitude
  logic                   neg_quo;   // operand signs differ
  logic                   neg_rem;   // dividend was negative
  logic                   div_zero;  // captured divisor was zero

  logic [DIV_WIDTH-1:0]   step_rem;
  logic [DIV_WIDTH-1:0]   step_quo;
  logic                   divisor_zero;

  assign divisor_zero = (divisor == '0);
  assign state_dbg    = state;

  div_step u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .dvs     (dvs_r),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = divisor_zero ? FIX : RUN;
        end
      end
      RUN: begin
        if (count == '0) begin
          state_nxt = FIX;
        end
      end
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count     <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      dvs_r     <= '0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      exception <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
    end else begin
      // busy covers every non-IDLE state; ready trails DONE by one edge so
      // busy drops exactly as ready rises.
      busy  <= (state_nxt != IDLE);
      ready <= (state == DONE);

      case (state)
        IDLE: begin
          if (start) begin
            rem_r     <= '0;
            quo_r     <= abs32(dividend);
            dvs_r     <= abs32(divisor);
            neg_quo   <= dividend[DIV_WIDTH-1] ^ divisor[DIV_WIDTH-1];
            neg_rem   <= dividend[DIV_WIDTH-1];
            div_zero  <= divisor_zero;
            count     <= divisor_zero ? '0 : DIV_CNT_W'(DIV_ITER - 1);
            quotient  <= '0;
            remainder <= '0;
            exception <= 1'b0;
          end
        end
        RUN: begin
          rem_r <= step_rem;
          quo_r <= step_quo;
          if (count != '0) begin
            count <= count - 1'b1;
          end
        end
        FIX: begin
          if (div_zero) begin
            quotient  <= '0;
            remainder <= '0;
            exception <= 1'b1;
          end else begin
            quotient  <= neg_quo ? neg32(quo_r) : quo_r;
            remainder <= neg_rem ? neg32(rem_r) : rem_r;
            exception <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit32_div.sv
// -----------------------------------------------------------------------------
// tb_bit32_div
// Directed plus random checks of bit32_div against an arithmetic reference
// (64-bit signed division / modulo, zero divisor mapped to the flagged case).
// -----------------------------------------------------------------------------
module tb_bit32_div;
  import bit32_div_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        ready;
  logic        exception;
  state_t      state_dbg;

  always #5 clock = ~clock;

  bit32_div dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .ready     (ready),
    .exception (exception),
    .state_dbg (state_dbg)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: truncating signed division done in 64 bits so that
  // -2^31 / -1 simply wraps when narrowed back to 32 bits.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic e);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = 32'd0;
      r = 32'd0;
      e = 1'b1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      e = 1'b0;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one complete division from IDLE, operands scrambled after accept
  // ---------------------------------------------------------------------------
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    logic        ee;
    int          k;
    int          nbusy;
    int          exp_lat;
    ref_div(a, b, eq, er, ee);
    exp_lat = (b == 32'd0) ? 2 : 34;
    @(negedge clock);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clock);
    @(negedge clock);
    start    = 1'b0;
    // outputs must already be cleared in the first cycle after acceptance
    check({tag, "_clr_q"}, quotient, 32'd0);
    check({tag, "_clr_r"}, remainder, 32'd0);
    check({tag, "_clr_e"}, {31'd0, exception}, 32'd0);
    dividend = $urandom;
    divisor  = $urandom;
    k     = 0;
    nbusy = 0;
    while (ready !== 1'b1 && k < 100) begin
      if (busy === 1'b1) nbusy++;
      @(posedge clock);
      k++;
      @(negedge clock);
    end
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_busy_cycles"}, nbusy, exp_lat);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_exception"}, {31'd0, exception}, {31'd0, ee});
    check({tag, "_busy_at_ready"}, {31'd0, busy}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    check({tag, "_ready_pulse"}, {31'd0, ready}, 32'd0);
    check({tag, "_hold_q"}, quotient, eq);
    check({tag, "_hold_r"}, remainder, er);
    check({tag, "_hold_e"}, {31'd0, exception}, {31'd0, ee});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          k;
    int          k1;
    int          nrdy;
    int          nbsy;

    // reset, with start held high so it must be ignored
    reset_n  = 1'b0;
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_exception", {31'd0, exception}, 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    start   = 1'b0;
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("post_rst_idle_busy", {31'd0, busy}, 32'd0);

    // directed scenarios
    run_div(32'd100, 32'd7, "d100_7");
    run_div(32'hFFFF_FF9C, 32'd7, "dm100_7");
    run_div(32'd100, 32'hFFFF_FFF9, "d100_m7");
    run_div(32'd12345, 32'd0, "div_zero");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, "min_by_m1");
    run_div(32'd5, 32'd9, "d5_9");
    run_div(32'h8000_0000, 32'd1, "min_by_1");
    run_div(32'h7FFF_FFFF, 32'h8000_0000, "max_by_min");
    run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, "dm7_m2");
    run_div(32'd0, 32'd3, "zero_by_3");

    // start pulsed during DONE must not launch a new division
    @(negedge clock);
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd6;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while (state_dbg != DONE && k < 100) begin
      @(posedge clock);
      k++;
      @(negedge clock);
    end
    check("done_reached", k, 33);
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    check("done_start_ready", {31'd0, ready}, 32'd1);
    check("done_start_q", quotient, 32'd8);
    check("done_start_r", remainder, 32'd2);
    @(posedge clock);
    @(negedge clock);
    check("done_start_ignored_busy", {31'd0, busy}, 32'd0);
    check("done_start_ignored_state", 32'(state_dbg), 32'(IDLE));

    // start held high, operands changed mid-RUN: one result per 35 cycles
    @(negedge clock);
    start    = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'hFFFF_FFFD;
    @(posedge clock);
    @(negedge clock);
    k = 0;
    while (ready !== 1'b1 && k < 100) begin
      @(posedge clock);
      k++;
      @(negedge clock);
      if (k == 10) begin
        dividend = 32'd77;
        divisor  = 32'd5;
      end
    end
    check("hold_first_latency", k, 34);
    check("hold_first_q", quotient, 32'hFFFF_FEB3);
    check("hold_first_r", remainder, 32'd1);
    k1 = k;
    @(posedge clock);
    k++;
    @(negedge clock);
    while (ready !== 1'b1 && k < 200) begin
      @(posedge clock);
      k++;
      @(negedge clock);
    end
    start = 1'b0;
    check("hold_period", k - k1, 35);
    check("hold_second_q", quotient, 32'd15);
    check("hold_second_r", remainder, 32'd2);
    @(posedge clock);
    @(negedge clock);
    check("hold_no_third", {31'd0, busy}, 32'd0);

    // reset in the middle of RUN aborts without a ready pulse
    @(negedge clock);
    start    = 1'b1;
    dividend = 32'd1234567;
    divisor  = 32'd89;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) begin
      @(posedge clock);
      @(negedge clock);
    end
    check("mid_run_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_exception", {31'd0, exception}, 32'd0);
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    nrdy = 0;
    nbsy = 0;
    repeat (40) begin
      @(posedge clock);
      @(negedge clock);
      if (ready !== 1'b0) nrdy++;
      if (busy !== 1'b0) nbsy++;
    end
    check("abort_no_ready", nrdy, 0);
    check("abort_no_busy", nbsy, 0);
    run_div(32'd81, 32'd9, "after_abort_81_9");

    // random operands, biased toward small values, signs and zero divisor
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = $urandom_range(0, 1000);
        1:       ra = 32'(-int'($urandom_range(0, 1000)));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'(-int'($urandom_range(1, 15)));
        default: rb = $urandom;
      endcase
      run_div(ra, rb, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit in case a wait above ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
